// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staged reset sequencer with round-robin soft-reset arbiter
//
// Purpose:
//   Sits downstream of the board reset synchronizer. After a power-on reset it
//   holds every downstream domain in reset, then releases the stages in
//   ascending order (memories, core, peripherals). Once idle it accepts level
//   soft-reset requests, grants one at a time round-robin, replays the same
//   staged sequence, and acknowledges the granted requester with a single pulse.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset (already synchronized)
//   soft_req     level soft-reset requests, held until the matching soft_ack
//   soft_ack     one-cycle completion pulse to the granted requester
//   stage_rst_n  active-low staged resets, bit 0 released first
//   busy         high while a power-on or soft sequence is in progress
//   last_src     index of the most recently granted requester
module rst_seq_ctrl #(
  parameter int NUM_REQ    = 3,
  parameter int NUM_STAGES = 3,
  parameter int HOLD_CYC   = 16,
  parameter int STAGE_GAP  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         soft_req,
  output logic [NUM_REQ-1:0]         soft_ack,
  output logic [NUM_STAGES-1:0]      stage_rst_n,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] last_src
);

  localparam int LW   = $clog2(NUM_REQ);
  localparam int MAXC = (HOLD_CYC > STAGE_GAP) ? HOLD_CYC : STAGE_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int SW   = $clog2(NUM_STAGES + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] LAST_STG  = SW'(NUM_STAGES - 1);
  localparam logic [LW-1:0] LAST_REQ  = LW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    ST_POR,
    ST_IDLE,
    ST_ASSERT,
    ST_RELEASE,
    ST_ACK
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           stg_q, stg_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    busy_q, busy_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [LW-1:0]           src_q, src_d;
  logic [LW-1:0]           ptr_q, ptr_d;

  // Round-robin pick: rotate the request vector so the pointer position lands
  // at bit 0, take the lowest set bit, then map the offset back to an index.
  logic [2*NUM_REQ-1:0]    req_dbl;
  logic [NUM_REQ-1:0]      req_rot;
  logic                    gnt_vld;
  logic [LW-1:0]           gnt_idx;
  int                      gnt_sum;

  always_comb begin
    req_dbl = {soft_req, soft_req};
    req_rot = NUM_REQ'(req_dbl >> ptr_q);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_sum = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_vld && req_rot[i]) begin
        gnt_vld = 1'b1;
        gnt_sum = int'(ptr_q) + i;
        if (gnt_sum >= NUM_REQ) begin
          gnt_sum = gnt_sum - NUM_REQ;
        end
        gnt_idx = LW'(gnt_sum);
      end
    end
  end

  // Decoded helpers: the stage being released next and the ack one-hot.
  logic [NUM_STAGES-1:0]   rel_mask;
  logic [NUM_REQ-1:0]      ack_onehot;

  always_comb begin
    rel_mask   = '0;
    ack_onehot = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      rel_mask[k] = (SW'(k) == stg_q);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      ack_onehot[k] = (LW'(k) == src_q);
    end
  end

  // The first release waits HOLD_CYC edges, later ones STAGE_GAP edges; the
  // counter restarts on every release so both intervals share one counter.
  logic tick_last;
  assign tick_last = (stg_q == '0) ? (cnt_q == HOLD_LAST) : (cnt_q == GAP_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    stage_d = stage_q;
    busy_d  = busy_q;
    ack_d   = '0;
    src_d   = src_q;
    ptr_d   = ptr_q;

    case (state_q)
      // POR shares the hold/release timing with soft sequences; it only
      // differs in where it ends (IDLE without an ack).
      ST_POR, ST_ASSERT, ST_RELEASE: begin
        if (tick_last) begin
          stage_d = stage_q | rel_mask;
          cnt_d   = '0;
          stg_d   = stg_q + SW'(1);
          if (stg_q == LAST_STG) begin
            state_d = (state_q == ST_POR) ? ST_IDLE : ST_ACK;
          end else if (state_q == ST_ASSERT) begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_IDLE: begin
        busy_d  = 1'b0;
        stage_d = '1;
        if (gnt_vld) begin
          src_d   = gnt_idx;
          ptr_d   = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + LW'(1);
          stage_d = '0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          stg_d   = '0;
          state_d = ST_ASSERT;
        end
      end

      // Two edges in ACK: the first raises the pulse, the second drops it and
      // clears busy on the way back to IDLE.
      ST_ACK: begin
        if (ack_q == '0) begin
          ack_d = ack_onehot;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_POR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_POR;
      cnt_q   <= '0;
      stg_q   <= '0;
      stage_q <= '0;
      busy_q  <= 1'b1;
      ack_q   <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign soft_ack    = ack_q;
  assign stage_rst_n = stage_q;
  assign busy        = busy_q;
  assign last_src    = src_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - scoreboard bench for rst_seq_ctrl
module tb_rst_seq_ctrl;

  localparam int H       = 16;
  localparam int G       = 4;
  localparam int DONE    = H + 2 * G;
  localparam int ACK_AT  = DONE + 1;
  localparam int IDLE_AT = DONE + 2;
  localparam int NEXT    = DONE + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] soft_req;
  logic [2:0] soft_ack;
  logic [2:0] stage_rst_n;
  logic       busy;
  logic [1:0] last_src;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rst_seq_ctrl #(
    .NUM_REQ   (3),
    .NUM_STAGES(3),
    .HOLD_CYC  (H),
    .STAGE_GAP (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soft_req   (soft_req),
    .soft_ack   (soft_ack),
    .stage_rst_n(stage_rst_n),
    .busy       (busy),
    .last_src   (last_src)
  );

  typedef struct packed {
    logic [2:0] stg;
    logic [2:0] ack;
    logic       bsy;
    logic [1:0] src;
  } out_t;

  typedef struct packed {
    int unsigned cyc;
    out_t        o;
  } ev_t;

  ev_t  exp_q[$];
  out_t prev_o;
  int   vecs = 0;
  int   errs = 0;

  task automatic push_ev(input int unsigned c, input logic [2:0] s, input logic [2:0] a,
                         input logic b, input logic [1:0] src);
    ev_t e;
    e.cyc   = c;
    e.o.stg = s;
    e.o.ack = a;
    e.o.bsy = b;
    e.o.src = src;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input int unsigned e0, input logic [1:0] src);
    logic [2:0] one;
    one = 3'b001;
    push_ev(e0,           3'b000, 3'b000,     1'b1, src);
    push_ev(e0 + H,       3'b001, 3'b000,     1'b1, src);
    push_ev(e0 + H + G,   3'b011, 3'b000,     1'b1, src);
    push_ev(e0 + DONE,    3'b111, 3'b000,     1'b1, src);
    push_ev(e0 + ACK_AT,  3'b111, one << src, 1'b1, src);
    push_ev(e0 + IDLE_AT, 3'b111, 3'b000,     1'b0, src);
  endtask

  task automatic tick();
    ev_t  e;
    ev_t  got;
    out_t now;
    @(negedge clk);
    now = {stage_rst_n, soft_ack, busy, last_src};
    vecs++;
    assert ($countones(soft_ack) <= 1) else begin
      errs++;
      $error("FAIL ack_onehot cyc=%0d soft_ack=%b required=at most one bit set", cyc, soft_ack);
    end
    if (now !== prev_o) begin
      got.cyc = cyc;
      got.o   = now;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e.cyc = 0;
        e.o   = '0;
      end
      vecs++;
      assert (got === e) else begin
        errs++;
        $error("FAIL out_event got cyc=%0d stg=%b ack=%b busy=%b src=%0d required cyc=%0d stg=%b ack=%b busy=%b src=%0d",
               got.cyc, got.o.stg, got.o.ack, got.o.bsy, got.o.src,
               e.cyc, e.o.stg, e.o.ack, e.o.bsy, e.o.src);
      end
    end
    prev_o = now;
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) tick();
  endtask

  initial begin
    int unsigned e0;
    int unsigned p;
    rst_n    = 1'b0;
    soft_req = 3'b000;
    prev_o   = 'x;

    // Power-on: reset for edges 1..5, counting starts at edge 6.
    push_ev(1, 3'b000, 3'b000, 1'b1, 2'd0);
    wait_cyc(5);
    rst_n = 1'b1;
    p = 5;
    push_ev(p + H,     3'b001, 3'b000, 1'b1, 2'd0);
    push_ev(p + H + G, 3'b011, 3'b000, 1'b1, 2'd0);
    push_ev(p + DONE,  3'b111, 3'b000, 1'b1, 2'd0);
    push_ev(p + DONE + 1, 3'b111, 3'b000, 1'b0, 2'd0);
    wait_cyc(p + DONE + 2);

    // Simultaneous requests served 0, 1, 2.
    soft_req = 3'b111;
    e0 = cyc + 1;
    push_seq(e0, 2'd0);
    wait_cyc(e0 + ACK_AT);
    soft_req[0] = 1'b0;
    e0 = e0 + NEXT;
    push_seq(e0, 2'd1);
    wait_cyc(e0 + ACK_AT);
    soft_req[1] = 1'b0;
    e0 = e0 + NEXT;
    push_seq(e0, 2'd2);
    wait_cyc(e0 + ACK_AT);
    soft_req[2] = 1'b0;
    wait_cyc(e0 + IDLE_AT);

    // Fairness: requester 0 re-requests right after its ack, 1 goes first.
    soft_req = 3'b011;
    e0 = cyc + 1;
    push_seq(e0, 2'd0);
    wait_cyc(e0 + ACK_AT);
    soft_req[0] = 1'b0;
    wait_cyc(e0 + IDLE_AT);
    soft_req[0] = 1'b1;
    e0 = e0 + NEXT;
    push_seq(e0, 2'd1);
    wait_cyc(e0 + ACK_AT);
    soft_req[1] = 1'b0;
    e0 = e0 + NEXT;
    push_seq(e0, 2'd0);
    wait_cyc(e0 + ACK_AT);
    soft_req[0] = 1'b0;
    wait_cyc(e0 + IDLE_AT);

    // Single request from requester 0.
    soft_req = 3'b001;
    e0 = cyc + 1;
    push_seq(e0, 2'd0);
    wait_cyc(e0 + ACK_AT);
    soft_req = 3'b000;
    wait_cyc(e0 + IDLE_AT);

    // Reset mid-sequence: request 1 aborted, held through POR, then re-served.
    soft_req = 3'b010;
    e0 = cyc + 1;
    push_ev(e0,     3'b000, 3'b000, 1'b1, 2'd1);
    push_ev(e0 + H, 3'b001, 3'b000, 1'b1, 2'd1);
    wait_cyc(e0 + H + 1);
    rst_n = 1'b0;
    push_ev(e0 + H + 2, 3'b000, 3'b000, 1'b1, 2'd0);
    wait_cyc(e0 + H + 3);
    rst_n = 1'b1;
    p = e0 + H + 3;
    push_ev(p + H,     3'b001, 3'b000, 1'b1, 2'd0);
    push_ev(p + H + G, 3'b011, 3'b000, 1'b1, 2'd0);
    push_ev(p + DONE,  3'b111, 3'b000, 1'b1, 2'd0);
    e0 = p + DONE + 1;
    push_seq(e0, 2'd1);
    wait_cyc(e0 + ACK_AT);
    soft_req = 3'b000;
    wait_cyc(e0 + IDLE_AT);

    // Late request: bit 2 rises during RELEASE and waits for IDLE.
    soft_req = 3'b001;
    e0 = cyc + 1;
    push_seq(e0, 2'd0);
    wait_cyc(e0 + H + 2);
    soft_req[2] = 1'b1;
    wait_cyc(e0 + ACK_AT);
    soft_req[0] = 1'b0;
    e0 = e0 + NEXT;
    push_seq(e0, 2'd2);
    wait_cyc(e0 + ACK_AT);
    soft_req = 3'b000;
    wait_cyc(e0 + IDLE_AT + 3);

    vecs++;
    assert (exp_q.size() == 0) else begin
      errs++;
      $error("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    vecs++;
    assert ({stage_rst_n, busy, soft_ack} === 7'b1110000) else begin
      errs++;
      $error("FAIL final_idle got stg=%b busy=%b ack=%b required stg=111 busy=0 ack=000",
             stage_rst_n, busy, soft_ack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer and soft-reset arbiter downstream of the board-level reset synchronizer.
- Takes the synchronized system reset plus soft-reset requests from several requesters (watchdog, debug/UART command, button-combo logic).
- Grants one requester at a time with round-robin arbitration.
- Drives staged, ordered reset releases to the downstream domains: memories first, then core, then peripherals.

Parameters:
NUM_REQ, 3, number of soft-reset requesters (legal range: 2 or more)
NUM_STAGES, 3, number of staged reset outputs; stage 0 is released first
HOLD_CYC, 16, cycles all stages are held low before stage 0 is released (legal range: 1 or more)
STAGE_GAP, 4, cycles between successive stage releases (legal range: 1 or more)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
soft_req  input  NUM_REQ  level soft-reset requests; each bit is held high until its soft_ack
soft_ack  output  NUM_REQ  one-cycle completion pulse to the granted requester
stage_rst_n  output  NUM_STAGES  active-low staged resets to downstream domains
busy  output  1  high while any sequence (power-on or soft) is in progress
last_src  output  $clog2(NUM_REQ)  index of the most recently granted requester

Behaviour:
- States: POR, IDLE, ASSERT, RELEASE, ACK. All outputs are registered.
- Counter width: $clog2(max(HOLD_CYC,STAGE_GAP)+1). Stage index width: $clog2(NUM_STAGES+1).

Reset (rst_n=0 at a clk edge):
- state=POR, counter=0, stage index=0.
- stage_rst_n=all 0, busy=1, soft_ack=0, last_src=0, RR pointer=0.
- Reset asserted mid-sequence aborts that sequence: no ack is issued, and the requester must keep holding its request, which is re-served later.

POR sequence:
- Counting starts at the first edge where rst_n=1.
- At the HOLD_CYC-th such edge, stage_rst_n[0] goes to 1.
- Stage k goes to 1 at edge HOLD_CYC + k*STAGE_GAP.
- On the edge that releases the last stage, state goes to IDLE and busy goes to 0 one edge later.
- No soft_ack is issued for POR.
- soft_req is ignored during POR.

IDLE:
- busy=0 and stage_rst_n=all 1.
- If any soft_req bit is high, grant the first set bit found searching upward (with wrap) from the RR pointer.
- At that edge, call it E0:
  - last_src <= grant index, RR pointer <= grant index + 1 (mod NUM_REQ);
  - stage_rst_n <= all 0, busy <= 1, state <= ASSERT.

ASSERT:
- Holds for HOLD_CYC edges.
- stage_rst_n[0] <= 1 at edge E0+HOLD_CYC, then state <= RELEASE.

RELEASE:
- stage_rst_n[k] <= 1 at edge E0+HOLD_CYC+k*STAGE_GAP.
- Release order is strictly ascending; once a stage is released it stays released until the next sequence.
- After the last stage is released, state <= ACK.

ACK:
- soft_ack[last_src]=1 for exactly one cycle, beginning one edge after the last stage release; busy stays 1.
- Next edge: soft_ack=0, busy=0, state=IDLE.

Request handling:
- Requests that arrive or change during ASSERT/RELEASE/ACK are ignored until IDLE; no queuing beyond the level-held soft_req.
- A requester must deassert soft_req on the edge after seeing soft_ack. If it is still high in IDLE, it is treated as a new request, subject to round-robin.
- Simultaneous requests: exactly one is granted; the others remain pending and are served in RR order.
- At most one soft_ack bit is high at any time.
- If NUM_STAGES=1, the sequence goes directly from ASSERT to ACK.

Test Plan:
- POR, defaults: rst_n low for 5 cycles, then high -> stage_rst_n=000 until edge 16 after release; bits 0/1/2 rise at edges 16/20/24; busy falls at edge 25; soft_ack never pulses.
- Single soft request: in IDLE, soft_req=001 -> stage_rst_n=000 at E0; bits 0/1/2 rise at E0+16/20/24; soft_ack=001 for 1 cycle at E0+25; busy=0 at E0+26; last_src=0.
- Simultaneous requests: soft_req=111 held, each bit dropped after its ack -> grants in order 0, 1, 2; three full sequences back-to-back, each separated by one IDLE cycle.
- RR fairness: requester 0 re-requests immediately after its ack while requester 1 is pending -> requester 1 is granted next; last_src=1.
- Reset mid-sequence: soft_req=010, rst_n pulled low at E0+18 (stage 0 released) -> stage_rst_n=000 next edge; no ack; after rst_n rises, the POR sequence runs, then req 1 is re-served with ack.
- Late request: soft_req[2] rises during RELEASE -> ignored until IDLE, then granted; never two soft_ack bits high at once.
